// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch control FSM states.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// Bundles the instruction-memory, decode and redirect signals of the fetch stage.
interface if_stage_if;
    import if_stage_pkg::*;

    logic               imem_req_o;
    logic [31:0]        imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [INSTR_W-1:0] imem_rdata_i;

    logic               id_valid_o;
    logic               id_ready_i;
    logic [INSTR_W-1:0] id_instr_o;
    logic [31:0]        id_pc_o;

    logic               redirect_i;
    logic [31:0]        redirect_pc_i;

    // Fetch stage side.
    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output id_valid_o, id_instr_o, id_pc_o,
        input  id_ready_i,
        input  redirect_i, redirect_pc_i
    );

    // Memory / decode / control side.
    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  id_valid_o, id_instr_o, id_pc_o,
        output id_ready_i,
        output redirect_i, redirect_pc_i
    );

endinterface

// File: rtl/if_stage_fetch_fifo.sv
// Two-entry buffer between instruction memory and decode; flush wins over push/pop.
module fetch_fifo
    import if_stage_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    localparam int DEPTH = 2;

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Next-state for pointers, count and storage.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != 2'd0);
        // A full buffer still accepts a push when the head leaves in the same cycle.
        do_push  = push_i && ((count_q != 2'd2) || do_pop);

        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the storage is reset too, because decode must see zero instr/pc out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding memory request, two-entry buffer to decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    if_stage_if.master   bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tag_q, tag_d;
    logic         req;
    logic         push, pop, flush;
    fetch_entry_t push_data, head;
    logic         fifo_full, fifo_empty;
    logic [1:0]   fifo_count;

    // Request gating, FSM next state, PC update and buffer control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        push    = 1'b0;
        flush   = 1'b0;
        // No request is outstanding while in REQ, so only buffered entries limit issue.
        req     = (state_q == REQ) && (int'(fifo_count) < BUF_DEPTH);
        pop     = !fifo_empty && bus.id_ready_i;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req && bus.imem_gnt_i) begin
                    state_d = bus.redirect_i ? DROP : WAIT;
                    tag_d   = pc_q;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    push    = !fifo_full;
                    state_d = REQ;
                end else if (bus.redirect_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides any PC step and discards both buffered and arriving data.
        if (bus.redirect_i) begin
            pc_d  = {bus.redirect_pc_i[31:2], 2'b00};
            flush = 1'b1;
            push  = 1'b0;
        end
    end

    // FSM, PC and request-tag registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tag_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
        end
    end

    assign push_data.instr = bus.imem_rdata_i;
    assign push_data.pc    = tag_q;

    fetch_fifo u_fetch_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_q;
    assign bus.id_valid_o  = !fifo_empty;
    assign bus.id_instr_o  = head.instr;
    assign bus.id_pc_o     = head.pc;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of fetched-instruction buffer entries; only value 2 is supported.
REQ-003 clk_i  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n_i  input  1  is the reset; it is asynchronous and active-low.
REQ-005 imem_req_o  output  1  is the instruction-memory request strobe.
REQ-006 imem_addr_o  output  32  is the word-aligned fetch address, valid while imem_req_o=1.
REQ-007 imem_gnt_i  input  1  indicates memory accepted the request this cycle.
REQ-008 imem_rvalid_i  input  1  indicates imem_rdata_i carries read data.
REQ-009 imem_rdata_i  input  32  is the instruction word.
REQ-010 id_valid_o  output  1  indicates id_instr_o/id_pc_o hold an instruction for decode.
REQ-011 id_ready_i  input  1  indicates decode accepts the instruction this cycle.
REQ-012 id_instr_o  output  32  is the instruction word to decode.
REQ-013 id_pc_o  output  32  is the address of id_instr_o.
REQ-014 redirect_i  input  1  is a branch/jump/flush request from later stages.
REQ-015 redirect_pc_i  input  32  is the new fetch address, sampled when redirect_i=1.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DROP; IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-017 REQ: drive imem_req_o=1 with imem_addr_o=pc_q only when buffer count plus outstanding requests < 2; otherwise imem_req_o=0 and stay in REQ.
REQ-018 REQ with imem_gnt_i=1: go to WAIT, latch pc_q as the request tag, set pc_q <= pc_q+4.
REQ-019 imem_addr_o SHALL stay stable from req assertion until gnt.
REQ-020 WAIT with imem_rvalid_i=1: push {imem_rdata_i, tag} into the buffer and go to REQ.
REQ-021 At most one memory request SHALL be outstanding.
REQ-022 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-023 Buffer is a 2-entry FIFO: id_valid_o = not empty; pop on id_valid_o && id_ready_i; push and pop in the same cycle SHALL keep the count unchanged, including when full.
REQ-024 Outputs SHALL come from registers; minimum latency from imem_rvalid_i to id_valid_o is 1 cycle.
REQ-025 Redirect has priority over every other event: pc_q <= {redirect_pc_i[31:2],2'b00}, buffer flushed, id_valid_o=0 on the next cycle.
REQ-026 Redirect in REQ without gnt: go to REQ with the new PC.
REQ-027 Redirect in REQ with gnt, or in WAIT without rvalid: go to DROP.
REQ-028 Redirect in WAIT with rvalid: discard the data and go to REQ.
REQ-029 DROP: discard the next imem_rvalid_i response without pushing, then go to REQ; a further redirect in DROP only updates pc_q.
REQ-030 Stall: id_ready_i=0 holds id_instr_o/id_pc_o stable while id_valid_o=1.

Reset
REQ-031 Asserting rst_n_i SHALL immediately set state=IDLE, pc_q=RESET_PC, buffer empty, imem_req_o=0, imem_addr_o=RESET_PC, id_valid_o=0, id_instr_o=0, id_pc_o=0.
REQ-032 Reset during WAIT SHALL drop the outstanding response; memory-side cleanup is the memory's responsibility.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, INSTR_W=32, PC_STEP=4, and the fetch-entry struct {instr, pc}.
REQ-034 The FIFO SHALL be the sub-module fetch_fifo (push, pop, flush, full, empty, count).

Verification
REQ-035 Reset release, gnt and rvalid 1 cycle after each request -> id_pc_o sequence 0x0,0x4,0x8 with matching words.
REQ-036 id_ready_i=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_o=0, outputs stable; release -> no loss or duplication.
REQ-037 Redirect to 0x0000_1002 while in WAIT -> late response discarded, next id_pc_o=0x0000_1000.
REQ-038 Redirect in the same cycle as gnt -> DROP entered, the following rvalid ignored, fetch resumes at the redirect PC.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> id_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 rst_n_i asserted mid-WAIT -> all outputs reach reset values asynchronously; the first request after release is at RESET_PC.
